// File: rtl/home_pkg.sv
// Shared home-security encodings: alarm causes (numeric order is priority) and sequencer states.
package home_pkg;

  localparam int CAUSE_W = 2;
  localparam int STATE_W = 2;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_BURGLAR = 2'd1,
    CAUSE_TAMPER  = 2'd2,
    CAUSE_FIRE    = 2'd3
  } cause_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_ALARM = 2'd2
  } state_e;

endpackage

// File: rtl/zone_priority_enc.sv
// Zone vector to (any-set, lowest set index) encoder.
module zone_priority_enc #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    // Scan downward so the lowest set bit is the last (winning) assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Security sequencer: arbitrates fire/tamper/burglar, runs the shared siren timer and
// drives the notifier req/ack handshake with one deep pending slot for upgrades.
module alarm_controller
  import home_pkg::*;
#(
  parameter int N_ZONES     = 4,
  parameter int ENTRY_DELAY = 30,
  parameter int ALARM_TIME  = 600,
  parameter int TW          = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick_1s,
  input  logic                       armed,
  input  logic [N_ZONES-1:0]         smoke,
  input  logic [N_ZONES-1:0]         intrusion,
  input  logic                       lockout,
  input  logic                       auth_ok,
  output logic                       siren,
  output logic [1:0]                 cause,
  output logic [$clog2(N_ZONES)-1:0] zone_id,
  output logic [1:0]                 state,
  output logic                       dial_req,
  output logic [1:0]                 dial_cause,
  input  logic                       dial_ack
);

  localparam int ZW = $clog2(N_ZONES);
  localparam logic [TW-1:0] T_ENTRY = TW'(ENTRY_DELAY);
  localparam logic [TW-1:0] T_ALARM = TW'(ALARM_TIME);
  localparam logic [TW-1:0] T_ONE   = TW'(1);

  state_e          state_q, state_d;
  cause_e          cause_q, cause_d, new_cause;
  logic [ZW-1:0]   zone_q, zone_d, new_zone;
  logic [TW-1:0]   timer_q, timer_d;
  logic            lock_q, lock_rise;
  logic            raise;
  logic            req_q, req_d, pend_q, pend_d;
  cause_e          dcause_q, dcause_d, pcause_q, pcause_d;

  logic            smoke_vld, intr_vld;
  logic [ZW-1:0]   smoke_idx, intr_idx;

  zone_priority_enc #(.N(N_ZONES), .W(ZW)) u_smoke_enc (
    .vec_i   (smoke),
    .valid_o (smoke_vld),
    .idx_o   (smoke_idx)
  );

  zone_priority_enc #(.N(N_ZONES), .W(ZW)) u_intr_enc (
    .vec_i   (intrusion & {N_ZONES{armed}}),
    .valid_o (intr_vld),
    .idx_o   (intr_idx)
  );

  assign lock_rise = lockout & ~lock_q;

  // Highest-priority cause presented this cycle; tamper carries no zone.
  always_comb begin
    new_cause = CAUSE_NONE;
    new_zone  = '0;
    if (smoke_vld) begin
      new_cause = CAUSE_FIRE;
      new_zone  = smoke_idx;
    end else if (lock_rise) begin
      new_cause = CAUSE_TAMPER;
    end else if (intr_vld) begin
      new_cause = CAUSE_BURGLAR;
      new_zone  = intr_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    zone_d  = zone_q;
    timer_d = timer_q;
    raise   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (new_cause == CAUSE_FIRE || new_cause == CAUSE_TAMPER) begin
          state_d = ST_ALARM;
          cause_d = new_cause;
          zone_d  = new_zone;
          timer_d = T_ALARM;
          raise   = 1'b1;
        end else if (intr_vld) begin
          state_d = ST_ENTRY;
          zone_d  = intr_idx;
          timer_d = T_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (new_cause == CAUSE_FIRE) begin
          state_d = ST_ALARM;
          cause_d = CAUSE_FIRE;
          zone_d  = new_zone;
          timer_d = T_ALARM;
          raise   = 1'b1;
        end else if (auth_ok || !armed) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
          zone_d  = '0;
          timer_d = '0;
        end else if (new_cause == CAUSE_TAMPER) begin
          state_d = ST_ALARM;
          cause_d = CAUSE_TAMPER;
          zone_d  = '0;
          timer_d = T_ALARM;
          raise   = 1'b1;
        end else if (tick_1s) begin
          if (timer_q == T_ONE) begin
            state_d = ST_ALARM;
            cause_d = CAUSE_BURGLAR;
            timer_d = T_ALARM;
            raise   = 1'b1;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
      end
      ST_ALARM: begin
        if (new_cause > cause_q) begin
          cause_d = new_cause;
          zone_d  = new_zone;
          timer_d = T_ALARM;
          raise   = 1'b1;
        end else if (auth_ok && cause_q != CAUSE_FIRE) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
          zone_d  = '0;
          timer_d = '0;
        end else if (cause_q == CAUSE_FIRE && smoke_vld) begin
          // Fire siren time only starts counting once every zone is clear.
          timer_d = T_ALARM;
        end else if (tick_1s) begin
          if (timer_q == T_ONE) begin
            state_d = ST_IDLE;
            cause_d = CAUSE_NONE;
            zone_d  = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cause_d = CAUSE_NONE;
        zone_d  = '0;
        timer_d = '0;
      end
    endcase
  end

  // A raise while a request is outstanding parks in the pending slot; it goes out
  // the cycle after the current request is accepted, so req drops for one cycle.
  always_comb begin
    req_d    = req_q;
    dcause_d = dcause_q;
    pend_d   = pend_q;
    pcause_d = pcause_q;
    if (req_q && dial_ack) req_d = 1'b0;
    if (!req_q && pend_q) begin
      req_d    = 1'b1;
      dcause_d = pcause_q;
      pend_d   = 1'b0;
    end
    if (raise) begin
      if (req_q) begin
        pend_d   = 1'b1;
        pcause_d = cause_d;
      end else begin
        req_d    = 1'b1;
        dcause_d = cause_d;
        pend_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cause_q  <= CAUSE_NONE;
      zone_q   <= '0;
      timer_q  <= '0;
      lock_q   <= 1'b0;
      req_q    <= 1'b0;
      dcause_q <= CAUSE_NONE;
      pend_q   <= 1'b0;
      pcause_q <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      zone_q   <= zone_d;
      timer_q  <= timer_d;
      lock_q   <= lockout;
      req_q    <= req_d;
      dcause_q <= dcause_d;
      pend_q   <= pend_d;
      pcause_q <= pcause_d;
    end
  end

  assign siren      = (state_q == ST_ALARM);
  assign cause      = cause_q;
  assign zone_id    = zone_q;
  assign state      = state_q;
  assign dial_req   = req_q;
  assign dial_cause = dcause_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: entry/burglar, auth abort, fire upgrade with
// pending notify, fire hold-off timing, tamper edge detection, async reset.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1s, armed, lockout, auth_ok, dial_ack;
  logic [3:0] smoke, intrusion;
  logic       siren, dial_req;
  logic [1:0] cause, state, dial_cause, zone_id;

  int total  = 0;
  int passed = 0;
  logic seen_siren, seen_req;

  alarm_controller #(
    .N_ZONES(4), .ENTRY_DELAY(30), .ALARM_TIME(600), .TW(10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1s    (tick_1s),
    .armed      (armed),
    .smoke      (smoke),
    .intrusion  (intrusion),
    .lockout    (lockout),
    .auth_ok    (auth_ok),
    .siren      (siren),
    .cause      (cause),
    .zone_id    (zone_id),
    .state      (state),
    .dial_req   (dial_req),
    .dial_cause (dial_cause),
    .dial_ack   (dial_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    seen_siren |= siren;
    seen_req   |= dial_req;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1s = 1'b1;
      step();
      tick_1s = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; tick_1s = 1'b0; armed = 1'b0; lockout = 1'b0;
    auth_ok = 1'b0; dial_ack = 1'b0; smoke = '0; intrusion = '0;
    seen_siren = 1'b0; seen_req = 1'b0;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_siren", 32'(siren), 0);
    chk("rst_cause", 32'(cause), 0);
    chk("rst_zone", 32'(zone_id), 0);
    chk("rst_req", 32'(dial_req), 0);
    chk("rst_dcause", 32'(dial_cause), 0);
    rst_n = 1'b1;

    // Burglar: entry delay then alarm
    armed = 1'b1; intrusion = 4'b0100;
    step();
    chk("t1_entry", 32'(state), 1);
    chk("t1_entry_zone", 32'(zone_id), 2);
    ticks(29);
    chk("t1_still_entry", 32'(state), 1);
    chk("t1_no_siren", 32'(siren), 0);
    ticks(1);
    chk("t1_alarm", 32'(state), 2);
    chk("t1_cause", 32'(cause), 1);
    chk("t1_zone", 32'(zone_id), 2);
    chk("t1_siren", 32'(siren), 1);
    chk("t1_req", 32'(dial_req), 1);
    chk("t1_dcause", 32'(dial_cause), 1);

    // Fire upgrade while request outstanding
    smoke = 4'b0001;
    step();
    chk("t3_cause", 32'(cause), 3);
    chk("t3_zone", 32'(zone_id), 0);
    chk("t3_req_held", 32'(dial_req), 1);
    chk("t3_dcause_stable", 32'(dial_cause), 1);
    dial_ack = 1'b1;
    step();
    dial_ack = 1'b0;
    chk("t3_req_drop", 32'(dial_req), 0);
    step();
    chk("t3_req_reraise", 32'(dial_req), 1);
    chk("t3_dcause_fire", 32'(dial_cause), 3);
    dial_ack = 1'b1;
    step();
    dial_ack = 1'b0;
    step();
    chk("t3_req_done", 32'(dial_req), 0);

    // Fire hold-off: ticks while smoke present don't count, auth ignored
    ticks(5);
    auth_ok = 1'b1;
    step();
    auth_ok = 1'b0;
    chk("t4_auth_ignored", 32'(state), 2);
    chk("t4_cause", 32'(cause), 3);
    smoke = 4'b0000;
    step();
    ticks(599);
    chk("t4_still_alarm", 32'(state), 2);
    chk("t4_still_siren", 32'(siren), 1);
    ticks(1);
    chk("t4_idle", 32'(state), 0);
    chk("t4_cause_clr", 32'(cause), 0);
    chk("t4_siren_off", 32'(siren), 0);
    step();
    chk("t4_reenter_entry", 32'(state), 1);
    auth_ok = 1'b1; intrusion = 4'b0000;
    step();
    auth_ok = 1'b0;
    chk("t4_auth_exit", 32'(state), 0);

    // Auth during entry delay
    intrusion = 4'b0100;
    step();
    seen_siren = 1'b0; seen_req = 1'b0;
    chk("t2_entry", 32'(state), 1);
    ticks(9);
    tick_1s = 1'b1; auth_ok = 1'b1; intrusion = 4'b0000;
    step();
    tick_1s = 1'b0; auth_ok = 1'b0;
    chk("t2_idle", 32'(state), 0);
    step();
    chk("t2_stay_idle", 32'(state), 0);
    chk("t2_no_siren", 32'(seen_siren), 0);
    chk("t2_no_req", 32'(seen_req), 0);

    // Tamper: edge-triggered, equal cause ignored, held level doesn't retrigger
    armed = 1'b0; lockout = 1'b1;
    step();
    chk("t5_alarm", 32'(state), 2);
    chk("t5_cause", 32'(cause), 2);
    chk("t5_zone", 32'(zone_id), 0);
    chk("t5_dcause", 32'(dial_cause), 2);
    dial_ack = 1'b1;
    step();
    dial_ack = 1'b0;
    lockout = 1'b0;
    step();
    lockout = 1'b1;
    step();
    chk("t5_equal_no_req", 32'(dial_req), 0);
    ticks(599);
    chk("t5_still_alarm", 32'(state), 2);
    ticks(1);
    chk("t5_idle", 32'(state), 0);
    step(); step(); step();
    chk("t5_held_no_retrig", 32'(state), 0);
    lockout = 1'b0;
    step();
    lockout = 1'b1;
    step();
    chk("t5_new_rise", 32'(state), 2);
    chk("t5_new_rise_cause", 32'(cause), 2);
    dial_ack = 1'b1;
    step();
    dial_ack = 1'b0;

    // Auth and expiry in the same cycle
    ticks(599);
    tick_1s = 1'b1; auth_ok = 1'b1;
    step();
    tick_1s = 1'b0; auth_ok = 1'b0;
    chk("t6_idle", 32'(state), 0);
    chk("t6_siren_off", 32'(siren), 0);

    // Async reset mid-alarm with request outstanding
    lockout = 1'b0;
    step();
    lockout = 1'b1;
    step();
    chk("t6_alarm", 32'(state), 2);
    chk("t6_req", 32'(dial_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_state", 32'(state), 0);
    chk("t6_rst_siren", 32'(siren), 0);
    chk("t6_rst_cause", 32'(cause), 0);
    chk("t6_rst_req", 32'(dial_req), 0);
    chk("t6_rst_dcause", 32'(dial_cause), 0);
    lockout = 1'b0;
    #20 rst_n = 1'b1;
    step(); step();
    chk("t6_post_rst_req", 32'(dial_req), 0);
    chk("t6_post_rst_state", 32'(state), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
